mem_port_arbiter: RTL and testbench

- Shares the single-port 8-bit memory between two requesters: the CPU fetch/execute sequencer and an IO/loader port (program load, DMA-style peeks).
- Sits between the requesters and the memory. It owns the memory read and write strobes, address and write data.
- Runs a request/grant/done handshake with round-robin fairness and a parameterised memory latency.

---
 rtl/risc_bus_pkg.sv | 16 +
 rtl/rr_arb2.sv | 35 +++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_bus_pkg.sv
// Shared bus types and constants for the memory port arbiter and future bus-owner arbiter.
package risc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_IO  = 1'b1;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the pointer only advances when update is asserted with a request present.
module rr_arb2
  import risc_bus_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       any,
  output logic       pick
);

  logic last_grant;

  always_comb begin
    any = |req;
    if (req == 2'b11) begin
      pick = ~last_grant;
    end else if (req[REQ_IO]) begin
      pick = REQ_IO;
    end else begin
      pick = REQ_CPU;
    end
  end

  // Pointer resets to IO so the CPU wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= REQ_IO;
    end else if (update && any) begin
      last_grant <= pick;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between the CPU sequencer and the IO/loader port.
module mem_port_arbiter
  import risc_bus_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_write,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_done,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..4");
  end

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  arb_state_t state;
  logic [1:0] cnt;
  logic       owner;
  logic       any_req;
  logic       pick;
  logic       pick_write;

  rr_arb2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    ({io_req, cpu_req}),
    .update (state == IDLE),
    .any    (any_req),
    .pick   (pick)
  );

  assign pick_write = (pick == REQ_IO) ? io_write : cpu_write;
  assign busy       = (state != IDLE);

  // mem_addr/mem_wdata double as the request latches; mem_read alone marks a read in ACCESS.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= REQ_CPU;
      cpu_gnt   <= 1'b0;
      io_gnt    <= 1'b0;
      cpu_done  <= 1'b0;
      io_done   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      io_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ACCESS;
            cnt       <= LAT_M1;
            owner     <= pick;
            cpu_gnt   <= (pick == REQ_CPU);
            io_gnt    <= (pick == REQ_IO);
            mem_addr  <= (pick == REQ_IO) ? io_addr : cpu_addr;
            mem_wdata <= (pick == REQ_IO) ? io_wdata : cpu_wdata;
            mem_write <= pick_write;
            mem_read  <= ~pick_write;
          end
        end
        ACCESS: begin
          mem_write <= 1'b0;
          if (cnt == '0) begin
            state    <= DONE;
            mem_read <= 1'b0;
            cpu_gnt  <= 1'b0;
            io_gnt   <= 1'b0;
            cpu_done <= (owner == REQ_CPU);
            io_done  <= (owner == REQ_IO);
            if (mem_read) begin
              if (owner == REQ_CPU) cpu_rdata <= mem_rdata;
              else                  io_rdata  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          cpu_done <= 1'b0;
          io_done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 1, 3, 2) share stimulus; each test checks the relevant instance.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset;
  logic cpu_req, cpu_write, io_req, io_write;
  logic [7:0] cpu_addr, cpu_wdata, io_addr, io_wdata;

  logic [2:0] cpu_gnt, cpu_done, io_gnt, io_done, mem_read, mem_write, busy;
  logic [7:0] cpu_rdata [3];
  logic [7:0] io_rdata  [3];
  logic [7:0] mem_addr  [3];
  logic [7:0] mem_wdata [3];
  logic [7:0] mem_rdata [3];
  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    assign mem_rdata[k] = mem[mem_addr[k]];
    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT)) dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_write (cpu_write),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt[k]),
      .cpu_done  (cpu_done[k]),
      .cpu_rdata (cpu_rdata[k]),
      .io_req    (io_req),
      .io_write  (io_write),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_gnt    (io_gnt[k]),
      .io_done   (io_done[k]),
      .io_rdata  (io_rdata[k]),
      .mem_read  (mem_read[k]),
      .mem_write (mem_write[k]),
      .mem_addr  (mem_addr[k]),
      .mem_wdata (mem_wdata[k]),
      .mem_rdata (mem_rdata[k]),
      .busy      (busy[k])
    );
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
    io_req = 0;  io_write = 0;  io_addr = '0;  io_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    next_cycle();
    next_cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({cpu_gnt[k], cpu_done[k], io_gnt[k], io_done[k], mem_read[k], mem_write[k], busy[k]} !== 7'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: got %b expected 0000000", k,
                 {cpu_gnt[k], cpu_done[k], io_gnt[k], io_done[k], mem_read[k], mem_write[k], busy[k]});
      end
      checks++;
      if ({mem_addr[k], mem_wdata[k], cpu_rdata[k], io_rdata[k]} !== 32'h0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got %h expected 00000000", k,
                 {mem_addr[k], mem_wdata[k], cpu_rdata[k], io_rdata[k]});
      end
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    mem[8'h10] = 8'h5A;
    cpu_req = 1; cpu_write = 0; cpu_addr = 8'h10;
    next_cycle(); // cycle 1
    checks++;
    if ({cpu_gnt[0], mem_read[0], mem_write[0], cpu_done[0], busy[0]} !== 5'b11001 || mem_addr[0] !== 8'h10) begin
      errors++;
      $display("FAIL cpu_read_c1: got ctrl=%b addr=%h expected ctrl=11001 addr=10",
               {cpu_gnt[0], mem_read[0], mem_write[0], cpu_done[0], busy[0]}, mem_addr[0]);
    end
    next_cycle(); // cycle 2
    checks++;
    if ({cpu_gnt[0], mem_read[0], cpu_done[0]} !== 3'b001 || cpu_rdata[0] !== 8'h5A) begin
      errors++;
      $display("FAIL cpu_read_c2: got ctrl=%b rdata=%h expected ctrl=001 rdata=5a",
               {cpu_gnt[0], mem_read[0], cpu_done[0]}, cpu_rdata[0]);
    end
    checks++;
    if ({io_gnt[0], io_done[0], io_rdata[0]} !== 10'b0) begin
      errors++;
      $display("FAIL cpu_read_io_quiet: got %h expected 000", {io_gnt[0], io_done[0], io_rdata[0]});
    end
    cpu_req = 0;
    next_cycle(); // cycle 3
    checks++;
    if ({cpu_done[0], busy[0], cpu_rdata[0]} !== {2'b00, 8'h5A}) begin
      errors++;
      $display("FAIL cpu_read_c3: got %h expected 05a", {cpu_done[0], busy[0], cpu_rdata[0]});
    end
  endtask

  task automatic test_tie();
    do_reset();
    mem[8'h20] = 8'h77;
    cpu_req = 1; cpu_write = 0; cpu_addr = 8'h20;
    io_req = 1;  io_write = 1;  io_addr = 8'h30; io_wdata = 8'hC3;
    next_cycle(); // cycle 1
    checks++;
    if ({cpu_gnt[0], io_gnt[0], mem_read[0], mem_write[0]} !== 4'b1010) begin
      errors++;
      $display("FAIL tie_c1: got %b expected 1010", {cpu_gnt[0], io_gnt[0], mem_read[0], mem_write[0]});
    end
    next_cycle(); // cycle 2
    checks++;
    if ({cpu_done[0], io_gnt[0]} !== 2'b10 || cpu_rdata[0] !== 8'h77) begin
      errors++;
      $display("FAIL tie_c2: got done/iognt=%b rdata=%h expected 10 rdata=77",
               {cpu_done[0], io_gnt[0]}, cpu_rdata[0]);
    end
    cpu_req = 0;
    next_cycle(); // cycle 3
    checks++;
    if ({io_gnt[0], busy[0], mem_write[0]} !== 3'b000) begin
      errors++;
      $display("FAIL tie_c3: got %b expected 000", {io_gnt[0], busy[0], mem_write[0]});
    end
    next_cycle(); // cycle 4
    checks++;
    if ({io_gnt[0], cpu_gnt[0], mem_write[0], mem_read[0]} !== 4'b1010 ||
        mem_addr[0] !== 8'h30 || mem_wdata[0] !== 8'hC3) begin
      errors++;
      $display("FAIL tie_c4: got ctrl=%b addr=%h wdata=%h expected ctrl=1010 addr=30 wdata=c3",
               {io_gnt[0], cpu_gnt[0], mem_write[0], mem_read[0]}, mem_addr[0], mem_wdata[0]);
    end
    next_cycle(); // cycle 5
    checks++;
    if ({io_done[0], io_gnt[0], mem_write[0]} !== 3'b100) begin
      errors++;
      $display("FAIL tie_c5: got %b expected 100", {io_done[0], io_gnt[0], mem_write[0]});
    end
    io_req = 0;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_v;
    do_reset();
    cpu_req = 1; cpu_write = 0; cpu_addr = 8'h20;
    io_req = 1;  io_write = 0;  io_addr = 8'h30;
    for (int t = 1; t <= 11; t++) begin
      next_cycle();
      exp_v[3] = (t % 3 == 1) && ((t / 3) % 2 == 0);
      exp_v[2] = (t % 3 == 1) && ((t / 3) % 2 == 1);
      exp_v[1] = (t % 3 == 2) && ((t / 3) % 2 == 0);
      exp_v[0] = (t % 3 == 2) && ((t / 3) % 2 == 1);
      checks++;
      if ({cpu_gnt[0], io_gnt[0], cpu_done[0], io_done[0]} !== exp_v) begin
        errors++;
        $display("FAIL fairness_c%0d: got gnt/done=%b expected %b", t,
                 {cpu_gnt[0], io_gnt[0], cpu_done[0], io_done[0]}, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_lat3();
    do_reset();
    mem[8'hFF] = 8'h81;
    io_req = 1; io_write = 0; io_addr = 8'hFF;
    for (int t = 1; t <= 3; t++) begin
      next_cycle();
      checks++;
      if ({io_gnt[1], mem_read[1], mem_write[1], io_done[1]} !== 4'b1100 || mem_addr[1] !== 8'hFF) begin
        errors++;
        $display("FAIL lat3_read_c%0d: got ctrl=%b addr=%h expected ctrl=1100 addr=ff", t,
                 {io_gnt[1], mem_read[1], mem_write[1], io_done[1]}, mem_addr[1]);
      end
    end
    next_cycle(); // cycle 4
    checks++;
    if ({io_gnt[1], mem_read[1], io_done[1]} !== 3'b001 || io_rdata[1] !== 8'h81) begin
      errors++;
      $display("FAIL lat3_done: got ctrl=%b rdata=%h expected ctrl=001 rdata=81",
               {io_gnt[1], mem_read[1], io_done[1]}, io_rdata[1]);
    end
    io_req = 0;
    next_cycle(); // cycle 5, IDLE
    io_req = 1; io_write = 1; io_addr = 8'h05; io_wdata = 8'h99;
    for (int t = 6; t <= 8; t++) begin
      next_cycle();
      checks++;
      if ({io_gnt[1], mem_read[1], mem_write[1]} !== {2'b10, (t == 6)}) begin
        errors++;
        $display("FAIL lat3_write_c%0d: got %b expected %b", t,
                 {io_gnt[1], mem_read[1], mem_write[1]}, {2'b10, (t == 6)});
      end
    end
    next_cycle(); // cycle 9
    checks++;
    if (io_done[1] !== 1'b1 || io_rdata[1] !== 8'h81) begin
      errors++;
      $display("FAIL lat3_rdata_hold: got done=%b rdata=%h expected done=1 rdata=81",
               io_done[1], io_rdata[1]);
    end
    io_req = 0;
  endtask

  task automatic test_reset_access();
    do_reset();
    cpu_req = 1; cpu_write = 1; cpu_addr = 8'h44; cpu_wdata = 8'h12;
    next_cycle(); // cycle 1
    checks++;
    if ({cpu_gnt[0], mem_write[0]} !== 2'b11) begin
      errors++;
      $display("FAIL rst_acc_c1: got %b expected 11", {cpu_gnt[0], mem_write[0]});
    end
    reset = 1;
    next_cycle(); // cycle 2
    reset = 0;
    checks++;
    if ({cpu_gnt[0], cpu_done[0], mem_read[0], mem_write[0], busy[0]} !== 5'b0 ||
        mem_addr[0] !== 8'h00 || mem_wdata[0] !== 8'h00) begin
      errors++;
      $display("FAIL rst_acc_c2: got ctrl=%b addr=%h wdata=%h expected 00000 00 00",
               {cpu_gnt[0], cpu_done[0], mem_read[0], mem_write[0], busy[0]}, mem_addr[0], mem_wdata[0]);
    end
    io_req = 1; io_write = 0; io_addr = 8'h30;
    next_cycle(); // cycle 3
    checks++;
    if ({cpu_gnt[0], io_gnt[0], mem_write[0]} !== 3'b101 || mem_addr[0] !== 8'h44) begin
      errors++;
      $display("FAIL rst_acc_tie: got ctrl=%b addr=%h expected ctrl=101 addr=44",
               {cpu_gnt[0], io_gnt[0], mem_write[0]}, mem_addr[0]);
    end
    next_cycle(); // cycle 4
    checks++;
    if ({cpu_done[0], io_done[0]} !== 2'b10) begin
      errors++;
      $display("FAIL rst_acc_done: got %b expected 10", {cpu_done[0], io_done[0]});
    end
    idle_inputs();
  endtask

  task automatic test_stability();
    do_reset();
    mem[8'h40] = 8'h3C;
    mem[8'h41] = 8'hAA;
    cpu_req = 1; cpu_write = 0; cpu_addr = 8'h40;
    next_cycle(); // cycle 1
    checks++;
    if ({cpu_gnt[2], mem_read[2]} !== 2'b11 || mem_addr[2] !== 8'h40) begin
      errors++;
      $display("FAIL stab_c1: got ctrl=%b addr=%h expected ctrl=11 addr=40",
               {cpu_gnt[2], mem_read[2]}, mem_addr[2]);
    end
    cpu_addr = 8'h41;
    next_cycle(); // cycle 2
    checks++;
    if ({cpu_gnt[2], mem_read[2], cpu_done[2]} !== 3'b110 || mem_addr[2] !== 8'h40) begin
      errors++;
      $display("FAIL stab_c2: got ctrl=%b addr=%h expected ctrl=110 addr=40",
               {cpu_gnt[2], mem_read[2], cpu_done[2]}, mem_addr[2]);
    end
    next_cycle(); // cycle 3
    checks++;
    if (cpu_done[2] !== 1'b1 || cpu_rdata[2] !== 8'h3C) begin
      errors++;
      $display("FAIL stab_done: got done=%b rdata=%h expected done=1 rdata=3c",
               cpu_done[2], cpu_rdata[2]);
    end
    idle_inputs();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    reset = 1;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_tie();
    test_fairness();
    test_lat3();
    test_reset_access();
    test_stability();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
